// File: rtl/strcpy_dma_pkg.sv
// strcpy_dma shared definitions: bus strobe levels, bus types
// and the 2-bit FSM encodings that the bus arbiter reuses.
package strcpy_dma_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef logic [7:0] addr_bus_t;
    typedef logic [7:0] data_bus_t;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2,
        DMA_DONE  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/strcpy_dma.sv
// strcpy_dma: byte-serial zero-terminated string copy engine.
// Optional STRCPY_ABORT_EN adds an abort input.
module strcpy_dma
    import strcpy_dma_pkg::*;
#(
    parameter int MAX_LEN = 256
) (
    input  logic      clk,
    input  logic      rst,
`ifdef STRCPY_ABORT_EN
    input  logic      abort,
`endif
    input  logic      start,
    input  addr_bus_t src,
    input  addr_bus_t dst,
    output addr_bus_t addr,
    output logic      rd_,
    output logic      wr_,
    output data_bus_t d_out,
    input  data_bus_t d_in,
    output logic      busy,
    output logic      done,
    output logic      err,
    output logic [8:0] count
);

    localparam logic [8:0] LAST_IDX = 9'(MAX_LEN - 1);

    dma_state_t state_q, state_d;
    addr_bus_t  sp_q, sp_d;
    addr_bus_t  dp_q, dp_d;
    data_bus_t  buf_q, buf_d;
    logic [8:0] count_q, count_d;
    logic       err_q, err_d;
    logic       abort_req;

`ifdef STRCPY_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            sp_q    <= '0;
            dp_q    <= '0;
            buf_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dp_q    <= dp_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        dp_d    = dp_q;
        buf_d   = buf_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    sp_d    = src;
                    dp_d    = dst;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                buf_d   = d_in;
                state_d = DMA_WRITE;
                if (abort_req) begin
                    state_d = DMA_DONE;
                    err_d   = 1'b1;
                end
            end
            DMA_WRITE: begin
                // The RAM commits this byte at the same edge,
                // so the write counts even when aborting.
                sp_d    = sp_q + 8'd1;
                dp_d    = dp_q + 8'd1;
                count_d = count_q + 9'd1;
                if (buf_q == 8'h00) begin
                    state_d = DMA_DONE;
                end else if (count_q == LAST_IDX) begin
                    state_d = DMA_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = DMA_READ;
                end
                if (abort_req) begin
                    state_d = DMA_DONE;
                    err_d   = 1'b1;
                end
            end
            DMA_DONE: begin
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // Moore decode of the memory bus from state and pointers.
    always_comb begin
        addr  = '0;
        d_out = '0;
        rd_   = DISABLE_;
        wr_   = DISABLE_;
        unique case (state_q)
            DMA_READ: begin
                addr = sp_q;
                rd_  = ENABLE_;
            end
            DMA_WRITE: begin
                addr  = dp_q;
                d_out = buf_q;
                wr_   = ENABLE_;
            end
            default: begin
                addr = '0;
            end
        endcase
    end

    assign busy  = (state_q != DMA_IDLE);
    assign done  = (state_q == DMA_DONE);
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: tb/tb_strcpy_dma.sv
// Self-checking bench for strcpy_dma with a behavioural RAM
// and a write scoreboard.
module tb_strcpy_dma;

    localparam int MAX_LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src, dst, addr, d_out, d_in;
    logic       rd_, wr_, busy, done, err;
    logic [8:0] count;
`ifdef STRCPY_ABORT_EN
    logic       abort;
`endif

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        int         cnt;
        int         err;
        int         lat;
    } vec_t;
    vec_t vecs[4];

    int n_pass = 0;
    int n_total = 0;
    int clash = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    strcpy_dma #(.MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef STRCPY_ABORT_EN
        .abort (abort),
`endif
        .start (start),
        .src   (src),
        .dst   (dst),
        .addr  (addr),
        .rd_   (rd_),
        .wr_   (wr_),
        .d_out (d_out),
        .d_in  (d_in),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count)
    );

    assign d_in = (rd_ == 1'b0) ? mem[addr] : 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    // RAM write port plus scoreboard of committed writes.
    always @(posedge clk) begin
        if (!rd_ && !wr_) clash <= clash + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (wr_ == 1'b0) begin
            mem[addr] <= d_out;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {24'h0, addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {24'h0, addr}, {24'h0, e.a});
                chk("wr_data", {24'h0, d_out}, {24'h0, e.d});
            end
        end
    end

    task automatic model_push(input logic [7:0] s, input logic [7:0] d);
        logic [7:0] b;
        for (int n = 0; n < MAX_LEN; n++) begin
            b = mem[8'(s + n)];
            exp_q.push_back('{a: 8'(d + n), d: b});
            if (b == 8'h00) break;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        model_push(v.src, v.dst);
        @(negedge clk);
        start = 1'b1;
        src = v.src;
        dst = v.dst;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) chk("busy_first", {31'h0, busy}, 1);
            c = i;
            if (done) break;
        end
        chk("done_lat", c, v.lat);
        chk("count", {23'h0, count}, v.cnt);
        chk("err", {31'h0, err}, v.err);
        @(negedge clk);
        chk("busy_after", {31'h0, busy}, 0);
        chk("done_after", {31'h0, done}, 0);
        chk("err_held", {31'h0, err}, v.err);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        src = '0;
        dst = '0;
`ifdef STRCPY_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[8'h10] = 8'h41; mem[8'h11] = 8'h42; mem[8'h12] = 8'h00;
        mem[8'h30] = 8'h00;
        mem[8'hFE] = 8'h61; mem[8'hFF] = 8'h62; mem[8'h00] = 8'h00;
        for (int i = 8'h50; i <= 8'h5F; i++) mem[i] = 8'(8'h80 + i);
        mem[8'h60] = 8'h31; mem[8'h61] = 8'h32; mem[8'h62] = 8'h33;
        mem[8'h63] = 8'h34; mem[8'h64] = 8'h00;

        vecs[0] = '{src: 8'h10, dst: 8'h20, cnt: 3, err: 0, lat: 7};
        vecs[1] = '{src: 8'h50, dst: 8'hA0, cnt: 4, err: 1, lat: 9};
        vecs[2] = '{src: 8'h30, dst: 8'h38, cnt: 1, err: 0, lat: 3};
        vecs[3] = '{src: 8'hFE, dst: 8'h40, cnt: 3, err: 0, lat: 7};

        repeat (3) @(negedge clk);
        chk("rst_addr", {24'h0, addr}, 0);
        chk("rst_dout", {24'h0, d_out}, 0);
        chk("rst_rd", {31'h0, rd_}, 1);
        chk("rst_wr", {31'h0, wr_}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err", {31'h0, err}, 0);
        chk("rst_count", {23'h0, count}, 0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) run_vec(vecs[k]);

        chk("mem_20", {24'h0, mem[8'h20]}, 32'h41);
        chk("mem_22", {24'h0, mem[8'h22]}, 32'h00);
        chk("mem_42", {24'h0, mem[8'h42]}, 32'h00);
        chk("mem_a4", {24'h0, mem[8'hA4]}, 32'hEE);

        // Reset during the third WRITE; a start while busy is ignored.
        exp_q.push_back('{a: 8'h70, d: 8'h31});
        exp_q.push_back('{a: 8'h71, d: 8'h32});
        exp_q.push_back('{a: 8'h72, d: 8'h33});
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        src = 8'h60;
        dst = 8'h70;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        src = 8'h10;
        dst = 8'h90;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w3_wr", {31'h0, wr_}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_busy", {31'h0, busy}, 0);
        chk("rstmid_rd", {31'h0, rd_}, 1);
        chk("rstmid_wr", {31'h0, wr_}, 1);
        @(negedge clk);
        chk("rstmid_nodone", done_cnt - d0, 0);
        chk("rstmid_sb", exp_q.size(), 0);
        chk("mem_73", {24'h0, mem[8'h73]}, 32'hEE);
        chk("mem_90", {24'h0, mem[8'h90]}, 32'hEE);

`ifdef STRCPY_ABORT_EN
        exp_q.push_back('{a: 8'h80, d: 8'h41});
        @(negedge clk);
        start = 1'b1;
        src = 8'h10;
        dst = 8'h80;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", {31'h0, done}, 1);
        chk("abort_err", {31'h0, err}, 1);
        chk("abort_count", {23'h0, count}, 1);
        @(negedge clk);
        chk("abort_sb", exp_q.size(), 0);
`endif

        chk("strobe_clash", clash, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
